alu_req_arbiter: RTL and testbench
==================================

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one ALU (legal 2..8).
REQ-002 Parameter ALU_LAT, default 1, cycles operands are held on the ALU before its result is sampled (legal 1..7).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_a  input  4*NUM_REQ  operand A per requester, requester i at bits [4i+3:4i].
REQ-007 req_b  input  4*NUM_REQ  operand B per requester, same packing.
REQ-008 req_op  input  2*NUM_REQ  opcode (alu_pkg opcode_t encoding) per requester, requester i at [2i+1:2i].
REQ-009 req_ready  output  NUM_REQ  one-hot acceptance strobe.
REQ-010 alu_a, alu_b  output  4 each  operands driven to ALU.
REQ-011 alu_op  output  2  opcode driven to ALU op.
REQ-012 alu_c  input  1  ALU carry output; alu_out  input  4  ALU data output.
REQ-013 resp_valid  output  1  response available; resp_ready  input  1  response consumer ready.
REQ-014 resp_result  output  5  captured {alu_c, alu_out}; resp_id  output  3  index of requester served.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-017 In IDLE with any req_valid high, the block SHALL assert req_ready for exactly one winner combinationally that cycle, latch its operands/opcode/index, and go to EXEC.
REQ-018 A request SHALL be accepted only in a cycle where req_valid[i] and req_ready[i] are both high; req_ready SHALL be zero in EXEC and RESP.
REQ-019 Arbitration SHALL be round-robin: search starts at index (last_grant+1) mod NUM_REQ, pointer reset value NUM_REQ-1 so requester 0 wins first.
REQ-020 In EXEC, alu_a/alu_b/alu_op SHALL hold latched values for exactly ALU_LAT cycles; on the last EXEC cycle {alu_c, alu_out} SHALL be registered into resp_result and the FSM SHALL go to RESP.
REQ-021 In RESP, resp_valid SHALL be high and resp_result/resp_id stable until resp_ready is sampled high; then return to IDLE the next cycle.
REQ-022 Minimum issue interval SHALL be ALU_LAT+2 cycles (accept, EXEC, RESP with resp_ready already high).
REQ-023 A requester dropping req_valid before acceptance SHALL lose its request without side effects; re-requests from the just-served requester SHALL rank lowest.
REQ-024 ALU outputs SHALL hold last issued values in IDLE and RESP (no toggling when idle).
REQ-025 Result width SHALL be 5 bits with carry in bit 4; no truncation or sign extension.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE, req_ready=0, resp_valid=0, resp_result=0, resp_id=0, alu_a=0, alu_b=0, alu_op=0, busy=0, pointer=NUM_REQ-1.
REQ-027 Reset in EXEC or RESP SHALL discard the in-flight operation; no response SHALL ever be produced for it.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIORITY_EN: when defined, arbitration SHALL be fixed priority (lowest index wins, pointer unused); when undefined, round-robin per REQ-019.

Verification
REQ-029 Single req: req 2 valid, a=4'hF, b=4'h1, op=ADD -> req_ready=4'b0100 same cycle, resp_valid after ALU_LAT+1 cycles, resp_result=5'h10, resp_id=2.
REQ-030 All four valid continuously, resp_ready=1 -> grant order 0,1,2,3,0 (ifndef macro); with macro defined -> 0,0,0,0.
REQ-031 Backpressure: resp_ready=0 for 10 cycles in RESP -> resp_valid and resp_result stable, req_ready stays 0, no new grant until release.
REQ-032 ALU_LAT=3: alu_a/alu_b/alu_op stable exactly 3 cycles in EXEC; result sampled on third cycle matches reference model.
REQ-033 rst_n pulsed low mid-EXEC -> all outputs zero asynchronously, no resp_valid afterward, next grant goes to requester 0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Shares one external ALU among NUM_REQ requesters: accept one in IDLE, hold operands ALU_LAT cycles, hold result until resp_ready.
// Round-robin by default; define ALU_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins).
module alu_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [4*NUM_REQ-1:0]   req_a,
    input  logic [4*NUM_REQ-1:0]   req_b,
    input  logic [2*NUM_REQ-1:0]   req_op,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [1:0]             alu_op,
    input  logic                   alu_c,
    input  logic [3:0]             alu_out,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [4:0]             resp_result,
    output logic [2:0]             resp_id,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [2:0] lat_cnt_q, lat_cnt_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic [4:0] result_q, result_d;
    logic [2:0] id_q, id_d;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
    logic [2:0] ptr_q, ptr_d;
`endif

    logic       win_vld;
    logic [2:0] win_idx;
    logic [3:0] win_a, win_b;
    logic [1:0] win_op;
    logic       exec_last;
    int         best_dist;
    int         cand_dist;

    // Rank every requester by distance from the search start; the smallest rank among valid ones wins.
    always_comb begin
        win_vld   = 1'b0;
        win_idx   = '0;
        win_a     = '0;
        win_b     = '0;
        win_op    = '0;
        best_dist = NUM_REQ;
        cand_dist = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            cand_dist = i;
`else
            cand_dist = (i + 2*NUM_REQ - 1 - int'(ptr_q)) % NUM_REQ;
`endif
            if (req_valid[i] && (cand_dist < best_dist)) begin
                best_dist = cand_dist;
                win_vld   = 1'b1;
                win_idx   = 3'(i);
                win_a     = req_a[4*i +: 4];
                win_b     = req_b[4*i +: 4];
                win_op    = req_op[2*i +: 2];
            end
        end
    end

    assign exec_last = (lat_cnt_q == 3'(ALU_LAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_vld)    state_d = EXEC;
            EXEC:    if (exec_last)  state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        lat_cnt_d = lat_cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        result_d  = result_q;
        id_d      = id_q;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
        ptr_d     = ptr_q;
`endif
        if ((state_q == IDLE) && win_vld) begin
            lat_cnt_d = '0;
            alu_a_d   = win_a;
            alu_b_d   = win_b;
            alu_op_d  = win_op;
            id_d      = win_idx;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
            ptr_d     = win_idx;
`endif
        end else if (state_q == EXEC) begin
            lat_cnt_d = lat_cnt_q + 3'd1;
            if (exec_last) result_d = {alu_c, alu_out};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt_q <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            result_q  <= '0;
            id_q      <= '0;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
            ptr_q     <= 3'(NUM_REQ - 1);
`endif
        end else begin
            lat_cnt_q <= lat_cnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            result_q  <= result_d;
            id_q      <= id_d;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    // req_ready is gated by rst_n so it drops the instant reset asserts, even with requests pending.
    always_comb begin
        req_ready  = '0;
        if (rst_n && (state_q == IDLE) && win_vld) req_ready = NUM_REQ'(1) << win_idx;
        busy       = (state_q != IDLE);
        resp_valid = (state_q == RESP);
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign resp_result = result_q;
    assign resp_id     = id_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter (NUM_REQ=4, ALU_LAT=3) with a latency-aware ALU and a transaction-level reference model.
module tb_alu_req_arbiter;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  rv;
    logic [4*N-1:0] req_a, req_b;
    logic [2*N-1:0] req_op;
    logic [N-1:0]  req_ready;
    logic [3:0]    alu_a, alu_b;
    logic [1:0]    alu_op;
    logic          alu_c   = 1'b0;
    logic [3:0]    alu_out = 4'h0;
    logic          resp_valid;
    logic          resp_ready;
    logic [4:0]    resp_result;
    logic [2:0]    resp_id;
    logic          busy;

    logic [3:0] ta  [N];
    logic [3:0] opb [N];
    logic [1:0] top [N];

    int n_cmp = 0;
    int n_err = 0;

    alu_req_arbiter #(.NUM_REQ(N), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_ready(req_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_c(alu_c), .alu_out(alu_out), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_result(resp_result), .resp_id(resp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[4*i +: 4]  = ta[i];
            req_b[4*i +: 4]  = opb[i];
            req_op[2*i +: 2] = top[i];
        end
    end

    // Opcodes: 0 ADD, 1 SUB (borrow in bit 4), 2 AND, 3 XOR.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU only produces the true result once operands have been steady LAT cycles; earlier it shows garbage.
    logic [3:0] pa = 4'h0, pb = 4'h0;
    logic [1:0] pop = 2'h0;
    int stab = 0;
    always @(negedge clk) begin
        if (alu_a == pa && alu_b == pb && alu_op == pop) stab++;
        else stab = 1;
        pa = alu_a; pb = alu_b; pop = alu_op;
        {alu_c, alu_out} = (stab >= LAT) ? alu_f(alu_a, alu_b, alu_op) : ~alu_f(alu_a, alu_b, alu_op);
    end

    function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < N; k++) if (v[k]) return k;
`else
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    // Reference model: one transaction in flight, aged in cycles since acceptance.
    bit         m_inflight = 0;
    int         m_age = 0;
    int         m_last = N - 1;
    int         m_id = 0;
    logic [3:0] m_a = 0, m_b = 0;
    logic [1:0] m_op = 0;
    logic [4:0] m_res = 0;

    always @(negedge clk) begin
        int win;
        logic [N-1:0] exp_rdy;
        bit exp_rv;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
            chk("rst_resp", {resp_result, resp_id}, 0);
            m_inflight = 0; m_age = 0; m_last = N - 1; m_id = 0;
            m_a = 0; m_b = 0; m_op = 0; m_res = 0;
        end else begin
            win = m_inflight ? -1 : pick(rv, m_last);
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            exp_rv = m_inflight && (m_age > LAT);
            chk("m_req_ready", req_ready, exp_rdy);
            chk("m_busy", busy, m_inflight);
            chk("m_resp_valid", resp_valid, exp_rv);
            chk("m_alu_ops", {alu_a, alu_b, alu_op}, {m_a, m_b, m_op});
            if (exp_rv) begin
                chk("m_resp_result", resp_result, m_res);
                chk("m_resp_id", resp_id, m_id);
            end
            if (win >= 0) begin
                m_inflight = 1; m_age = 1; m_id = win; m_last = win;
                m_a = ta[win]; m_b = opb[win]; m_op = top[win];
                m_res = alu_f(m_a, m_b, m_op);
            end else if (m_inflight) begin
                if (exp_rv && resp_ready) m_inflight = 0;
                else m_age++;
            end
        end
    end

    bit rec_en = 0;
    int gq[$];
    int gt[$];
    int cyc_n = 0;
    always @(posedge clk) cyc_n++;
    always @(negedge clk) begin
        if (rec_en && rst_n && req_ready != 0) begin
            for (int i = 0; i < N; i++) if (req_ready[i]) gq.push_back(i);
            gt.push_back(cyc_n);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin cyc(1); n++; end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        int n, exec_cnt;
        int exp_order[5];
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        rst_n = 1'b0; rv = '1; resp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin ta[i] = 0; opb[i] = 0; top[i] = 0; end
        cyc(2);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_resp", {resp_valid, resp_result, resp_id}, 0);
        chk("reset_alu", {alu_a, alu_b, alu_op}, 0);
        rv = '0;
        rst_n = 1'b1;
        cyc(1);

        // Single request from requester 2: F + 1 = 0x10 with carry.
        ta[2] = 4'hF; opb[2] = 4'h1; top[2] = 2'd0; rv = 4'b0100;
        #1 chk("single_ready", req_ready, 4'b0100);
        cyc(1); rv = '0;
        n = 1; exec_cnt = 0;
        while (!resp_valid && n < 20) begin
            if (busy) exec_cnt++;
            cyc(1); n++;
        end
        chk("single_latency", n, LAT + 1);
        chk("exec_cycles", exec_cnt, LAT);
        chk("single_result", resp_result, 5'h10);
        chk("single_id", resp_id, 3'd2);
        cyc(1);
        chk("single_done", busy, 0);

        // Back-to-back contention from a fresh reset.
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        gq.delete(); gt.delete();
        for (int i = 0; i < N; i++) begin ta[i] = 4'(i + 5); opb[i] = 4'(3 * i); top[i] = 2'(i); end
        rec_en = 1; rv = '1; resp_ready = 1'b1;
        n = 0;
        while (gq.size() < 5 && n < 80) begin cyc(1); n++; end
        rv = '0; rec_en = 0;
        chk("grant_count", gq.size(), 5);
        for (int i = 0; i < 5; i++) chk("grant_order", (i < gq.size()) ? gq[i] : -1, exp_order[i]);
        chk("issue_gap", (gt.size() > 1) ? gt[1] - gt[0] : -1, LAT + 2);
        wait_idle();

        // Backpressure: 3 - 5 = 0x1E (borrow set), held 10 cycles.
        resp_ready = 1'b0;
        ta[1] = 4'h3; opb[1] = 4'h5; top[1] = 2'd1; rv = 4'b0010;
        #1 chk("bp_grant", req_ready, 4'b0010);
        cyc(1); rv = '1;
        n = 0;
        while (!resp_valid && n < 20) begin cyc(1); n++; end
        for (int i = 0; i < 10; i++) begin
            chk("bp_resp_valid", resp_valid, 1);
            chk("bp_resp_result", resp_result, 5'h1E);
            chk("bp_resp_id", resp_id, 3'd1);
            chk("bp_req_ready", req_ready, 0);
            cyc(1);
        end
        resp_ready = 1'b1;
        cyc(1);
        chk("bp_release", resp_valid, 0);
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        chk("bp_next_grant", req_ready, 4'b0001);
`else
        chk("bp_next_grant", req_ready, 4'b0100);
`endif
        rv = '0;
        wait_idle();

        // Reset in the middle of EXEC.
        rv = 4'b1000; ta[3] = 4'h9; opb[3] = 4'h9; top[3] = 2'd0;
        cyc(1); rv = '1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_req_ready", req_ready, 0);
        chk("async_resp", {resp_valid, resp_result, resp_id}, 0);
        chk("async_alu", {alu_a, alu_b, alu_op}, 0);
        cyc(1);
        rst_n = 1'b1;
        #1 chk("post_rst_grant", req_ready, 4'b0001);
        cyc(1); rv = '0;
        wait_idle();

        // Random traffic, requests may drop before acceptance.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                ta[i]  = 4'($urandom_range(0, 15));
                opb[i] = 4'($urandom_range(0, 15));
                top[i] = 2'($urandom_range(0, 3));
            end
            rv = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        rv = '0; resp_ready = 1'b1;
        wait_idle();
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
